pattern_det_ctrl: RTL and testbench

PATTERN_DET_CTRL -- requirements
Module: pattern_det_ctrl

---
 rtl/pattern_det_pkg.sv | 16 +
 rtl/pattern_det_ctrl_if.sv | 33 +++
 rtl/pattern_matcher.sv | 45 ++++
 rtl/pattern_det_ctrl.sv | 94 +++++++++
 tb/tb_pattern_det_ctrl.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/pattern_det_pkg.sv
// pattern_det_pkg: shared types and defaults for the serial pattern detector.
// Holds the controller state enum, default widths and the configuration
// loaded on reset. No ports.
package pattern_det_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

    localparam int MAXW_DEF = 8;
    localparam int CNTW_DEF = 8;

    localparam logic [3:0] RST_PATTERN  = 4'b1010;
    localparam int         RST_LEN      = 4;
    localparam logic       RST_OVERLAP  = 1'b1;
    localparam int         RST_MAX_HITS = 0;

endpackage

// File: rtl/pattern_det_ctrl_if.sv
// pattern_det_ctrl_if: bundles the detector's data, config, command and status signals.
// Ports: none. master drives din/din_vld/cfg_*/start/abort and observes
// busy/hit/hit_cnt/done; slave is the detector side.
interface pattern_det_ctrl_if import pattern_det_pkg::*; #(
    parameter int MAXW = MAXW_DEF,
    parameter int CNTW = CNTW_DEF,
    parameter int LW   = $clog2(MAXW) + 1
);
    logic            din;
    logic            din_vld;
    logic            cfg_we;
    logic [MAXW-1:0] cfg_pattern;
    logic [LW-1:0]   cfg_len;
    logic            cfg_overlap;
    logic [CNTW-1:0] cfg_max_hits;
    logic            start;
    logic            abort;
    logic            busy;
    logic            hit;
    logic [CNTW-1:0] hit_cnt;
    logic            done;

    modport master (
        output din, din_vld, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_max_hits, start, abort,
        input  busy, hit, hit_cnt, done
    );

    modport slave (
        input  din, din_vld, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_max_hits, start, abort,
        output busy, hit, hit_cnt, done
    );

endinterface

// File: rtl/pattern_matcher.sv
// pattern_matcher: shift history, fill count and pattern compare.
// Ports: clk, resetn (sync, active-low); clr empties history and fill;
// en consumes din this cycle; pattern/len/overlap are the active config;
// match is the combinational hit flag for the bit being consumed.
module pattern_matcher import pattern_det_pkg::*; #(
    parameter  int MAXW = MAXW_DEF,
    localparam int LW   = $clog2(MAXW) + 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            clr,
    input  logic            en,
    input  logic            din,
    input  logic [MAXW-1:0] pattern,
    input  logic [LW-1:0]   len,
    input  logic            overlap,
    output logic            match
);
    logic [MAXW-1:0] hist;
    logic [MAXW-1:0] cand;
    logic [MAXW-1:0] mask;
    logic [LW-1:0]   fill;
    logic [LW-1:0]   fill_inc;

    // The compare uses the history as it will look after this bit is shifted in.
    always_comb begin
        cand     = {hist[MAXW-2:0], din};
        mask     = ~({MAXW{1'b1}} << len);
        fill_inc = (fill == LW'(MAXW)) ? fill : fill + LW'(1);
        match    = en && (fill_inc >= len) && (((cand ^ pattern) & mask) == '0);
    end

    // Without overlap, emptying the fill count forces a full fresh pattern
    // before the next match, so no bit is shared between matches.
    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            hist <= '0;
            fill <= '0;
        end else if (en) begin
            hist <= cand;
            fill <= (match && !overlap) ? '0 : fill_inc;
        end
    end

endmodule

// File: rtl/pattern_det_ctrl.sv
// pattern_det_ctrl: armed serial pattern detector with hit counting and auto-stop.
// Ports: clk, resetn (sync, active-low); bus (slave) carries din/din_vld,
// cfg_we with cfg_pattern/cfg_len/cfg_overlap/cfg_max_hits, start/abort
// commands, and busy/hit/hit_cnt/done status.
module pattern_det_ctrl import pattern_det_pkg::*; #(
    parameter int MAXW = MAXW_DEF,
    parameter int CNTW = CNTW_DEF
) (
    input logic                clk,
    input logic                resetn,
    pattern_det_ctrl_if.slave  bus
);
    localparam int LW = $clog2(MAXW) + 1;

    state_t          state;
    state_t          state_nx;
    logic [MAXW-1:0] pat_q;
    logic [LW-1:0]   len_q;
    logic            ovl_q;
    logic [CNTW-1:0] max_q;
    logic            hit_q;
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_inc;
    logic [LW-1:0]   len_clamp;
    logic            idle_like;
    logic            arm;
    logic            take;
    logic            match;

    // abort beats start; a bit arriving together with abort is dropped so it
    // can neither hit nor count.
    always_comb begin
        idle_like = (state != ARMED);
        arm       = idle_like && bus.start && !bus.abort;
        take      = (state == ARMED) && bus.din_vld && !bus.abort;
        cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNTW'(1);
        len_clamp = (bus.cfg_len == '0) ? LW'(1) :
                    (bus.cfg_len > LW'(MAXW)) ? LW'(MAXW) : bus.cfg_len;
        state_nx  = bus.abort ? IDLE :
                    arm ? ARMED :
                    (match && (max_q != '0) && (cnt_inc == max_q)) ? DONE : state;
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Config is frozen while armed; a write alongside start lands on the same
    // edge, so that arming already runs with it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pat_q <= MAXW'(RST_PATTERN);
            len_q <= LW'(RST_LEN);
            ovl_q <= RST_OVERLAP;
            max_q <= CNTW'(RST_MAX_HITS);
        end else if (bus.cfg_we && idle_like) begin
            pat_q <= bus.cfg_pattern;
            len_q <= len_clamp;
            ovl_q <= bus.cfg_overlap;
            max_q <= bus.cfg_max_hits;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hit_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            hit_q <= match;
            cnt_q <= arm ? '0 : match ? cnt_inc : cnt_q;
        end
    end

    pattern_matcher #(.MAXW(MAXW)) u_matcher (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (arm),
        .en      (take),
        .din     (bus.din),
        .pattern (pat_q),
        .len     (len_q),
        .overlap (ovl_q),
        .match   (match)
    );

    assign bus.busy    = (state == ARMED);
    assign bus.done    = (state == DONE);
    assign bus.hit     = hit_q;
    assign bus.hit_cnt = cnt_q;

endmodule

// File: tb/tb_pattern_det_ctrl.sv
// tb_pattern_det_ctrl: directed self-checking bench for pattern_det_ctrl.
// Ports: none; drives the detector through a pattern_det_ctrl_if instance.
module tb_pattern_det_ctrl;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pattern_det_ctrl_if #(.MAXW(8), .CNTW(8)) bus ();

    pattern_det_ctrl #(.MAXW(8), .CNTW(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic ovl,
                       input logic [7:0] mh, input logic st);
        bus.cfg_pattern  = p;
        bus.cfg_len      = l;
        bus.cfg_overlap  = ovl;
        bus.cfg_max_hits = mh;
        bus.cfg_we       = 1'b1;
        bus.start        = st;
        tick();
        bus.cfg_we       = 1'b0;
        bus.start        = 1'b0;
    endtask

    task automatic pulse_start;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_abort;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    // bits/hits are listed first-bit-first in the low n positions
    task automatic feed(input string tag, input logic [15:0] bits, input int n, input logic [15:0] hits);
        for (int i = 0; i < n; i++) begin
            bus.din     = bits[n-1-i];
            bus.din_vld = 1'b1;
            tick();
            check($sformatf("%s bit%0d hit", tag, i + 1), {31'd0, bus.hit}, {31'd0, hits[n-1-i]});
        end
        bus.din_vld = 1'b0;
    endtask

    task automatic status(input string tag, input logic b, input logic d, input logic [7:0] c);
        check({tag, " busy"},    {31'd0, bus.busy}, {31'd0, b});
        check({tag, " done"},    {31'd0, bus.done}, {31'd0, d});
        check({tag, " hit_cnt"}, {24'd0, bus.hit_cnt}, {24'd0, c});
    endtask

    initial begin
        bus.din = 1'b0; bus.din_vld = 1'b0; bus.cfg_we = 1'b0; bus.cfg_pattern = '0;
        bus.cfg_len = '0; bus.cfg_overlap = 1'b0; bus.cfg_max_hits = '0;
        bus.start = 1'b0; bus.abort = 1'b0;
        tick(); tick();
        status("rst", 1'b0, 1'b0, 8'd0);
        check("rst hit", {31'd0, bus.hit}, 32'd0);
        resetn = 1'b1;

        // default config 1010/len4/overlap
        pulse_start();
        status("t1 armed", 1'b1, 1'b0, 8'd0);
        feed("t1", 16'b101010, 6, 16'b000101);
        status("t1 end", 1'b1, 1'b0, 8'd2);
        pulse_start();
        status("t1 restart ignored", 1'b1, 1'b0, 8'd2);

        // no overlap; config written together with start
        pulse_abort();
        status("t2 idle", 1'b0, 1'b0, 8'd2);
        cfg(8'h0A, 4'd4, 1'b0, 8'd0, 1'b1);
        status("t2 armed", 1'b1, 1'b0, 8'd0);
        feed("t2", 16'b101010, 6, 16'b000100);
        status("t2 end", 1'b1, 1'b0, 8'd1);

        // 110, max_hits 2 -> auto-stop
        pulse_abort();
        cfg(8'h06, 4'd3, 1'b1, 8'd2, 1'b1);
        feed("t3", 16'b110110, 6, 16'b001001);
        status("t3 done", 1'b0, 1'b1, 8'd2);
        feed("t3 ignored", 16'b110, 3, 16'b000);
        status("t3 still done", 1'b0, 1'b1, 8'd2);
        pulse_abort();
        status("t3 abort in done", 1'b0, 1'b0, 8'd2);

        // gaps in din_vld change nothing
        cfg(8'h0A, 4'd4, 1'b1, 8'd0, 1'b1);
        feed("t4 a", 16'b10, 2, 16'b00);
        bus.din = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t4 gap%0d hit", i), {31'd0, bus.hit}, 32'd0);
        end
        feed("t4 b", 16'b10, 2, 16'b01);
        status("t4 end", 1'b1, 1'b0, 8'd1);

        // abort coinciding with a matching bit
        pulse_abort();
        pulse_start();
        feed("t5", 16'b1010_00101, 9, 16'b0001_00000);
        bus.din = 1'b0; bus.din_vld = 1'b1; bus.abort = 1'b1;
        tick();
        bus.din_vld = 1'b0; bus.abort = 1'b0;
        check("t5 abort hit", {31'd0, bus.hit}, 32'd0);
        status("t5 abort", 1'b0, 1'b0, 8'd1);
        tick();
        check("t5 after hit", {31'd0, bus.hit}, 32'd0);

        // config write while armed is ignored
        pulse_start();
        cfg(8'h05, 4'd3, 1'b0, 8'd1, 1'b0);
        feed("t6 a", 16'b1010, 4, 16'b0001);
        status("t6 a", 1'b1, 1'b0, 8'd1);

        // reset mid-stream restores default config
        pulse_abort();
        cfg(8'h05, 4'd3, 1'b0, 8'd1, 1'b1);
        feed("t6 b", 16'b10, 2, 16'b00);
        bus.din = 1'b1; bus.din_vld = 1'b1; resetn = 1'b0;
        tick();
        bus.din_vld = 1'b0;
        status("t6 rst", 1'b0, 1'b0, 8'd0);
        check("t6 rst hit", {31'd0, bus.hit}, 32'd0);
        resetn = 1'b1;
        tick();
        check("t6 post rst hit", {31'd0, bus.hit}, 32'd0);
        pulse_start();
        feed("t6 c", 16'b101010, 6, 16'b000101);
        status("t6 c", 1'b1, 1'b0, 8'd2);

        // length clamping
        pulse_abort();
        cfg(8'h01, 4'd0, 1'b1, 8'd0, 1'b1);
        feed("t7 len0", 16'b101, 3, 16'b101);
        pulse_abort();
        cfg(8'hA5, 4'd15, 1'b1, 8'd0, 1'b1);
        feed("t7 len15", 16'b10100101, 8, 16'b00000001);

        // hit_cnt saturation with max_hits 0
        pulse_abort();
        cfg(8'h01, 4'd1, 1'b1, 8'd0, 1'b1);
        bus.din = 1'b1; bus.din_vld = 1'b1;
        for (int i = 0; i < 260; i++) tick();
        bus.din_vld = 1'b0;
        check("t8 sat hit", {31'd0, bus.hit}, 32'd1);
        status("t8 sat", 1'b1, 1'b0, 8'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
